// File: rtl/fp_cmp_pkg.sv
// Shared encodings for the single-precision compare stage: condition codes,
// FSM states and IEEE-754 field positions.
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        CondEq   = 2'b00,
        CondLt   = 2'b01,
        CondLe   = 2'b10,
        CondRsvd = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StClassify = 2'b01,
        StCompare  = 2'b10,
        StWrite    = 2'b11
    } state_e;

    localparam int unsigned SIGN_BIT  = 31;
    localparam int unsigned EXP_MSB   = 30;
    localparam int unsigned EXP_LSB   = 23;
    localparam int unsigned MANT_W    = 23;
    localparam int unsigned QUIET_BIT = 22;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one single-precision operand.
// Denormals are not flagged; they fall through to raw-magnitude ordering.
module fp_classify
    import fp_cmp_pkg::*;
(
    input  logic [31:0] value,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_zero,
    output logic        sign
);

    logic [EXP_MSB-EXP_LSB:0] exp_f;
    logic [MANT_W-1:0]        mant_f;

    assign exp_f   = value[EXP_MSB:EXP_LSB];
    assign mant_f  = value[MANT_W-1:0];

    assign is_nan  = (&exp_f) && (|mant_f);
    assign is_snan = is_nan && !mant_f[QUIET_BIT];
    assign is_zero = (~|exp_f) && (~|mant_f);
    assign sign    = value[SIGN_BIT];

endmodule

// File: rtl/fp_compare_stage.sv
// Four-state FP compare stage writing a one-bit result into a condition-flag bank.
// Define FP_COMPARE_INVALID_EN to add the oInvalid exception strobe.
module fp_compare_stage
    import fp_cmp_pkg::*;
#(
    parameter int unsigned FLAG_W = 3
) (
    input  logic              iCLK,
    input  logic              iCLR_N,
    input  logic              iStart,
    input  logic [31:0]       iA,
    input  logic [31:0]       iB,
    input  logic [1:0]        iCond,
    input  logic [FLAG_W-1:0] iFlagSel,
    output logic              oBusy,
    output logic              oFlagWrite,
    output logic [FLAG_W-1:0] oFlag,
    output logic              oData,
    output logic              oDone
`ifdef FP_COMPARE_INVALID_EN
    ,
    output logic              oInvalid
`endif
);

    state_e state_q, state_d;

    logic [31:0]       a_q, b_q;
    logic [1:0]        cond_q;
    logic [FLAG_W-1:0] flag_sel_q;
    logic [FLAG_W-1:0] flag_q;
    logic              data_q;

    logic a_nan, a_zero, a_sign, b_nan, b_zero, b_sign;
    logic a_nan_q, a_zero_q, a_sign_q, b_nan_q, b_zero_q, b_sign_q;

    logic any_nan, both_zero, eq, lt, result;

`ifdef FP_COMPARE_INVALID_EN
    logic a_snan, b_snan, a_snan_q, b_snan_q;
    logic invalid, invalid_q;
`endif

    fp_classify u_class_a (
        .value   (a_q),
        .is_nan  (a_nan),
`ifdef FP_COMPARE_INVALID_EN
        .is_snan (a_snan),
`else
        .is_snan (),
`endif
        .is_zero (a_zero),
        .sign    (a_sign)
    );

    fp_classify u_class_b (
        .value   (b_q),
        .is_nan  (b_nan),
`ifdef FP_COMPARE_INVALID_EN
        .is_snan (b_snan),
`else
        .is_snan (),
`endif
        .is_zero (b_zero),
        .sign    (b_sign)
    );

    // State register
    always_ff @(posedge iCLK or negedge iCLR_N) begin
        if (!iCLR_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (iStart) state_d = StClassify;
            StClassify: state_d = StCompare;
            StCompare:  state_d = StWrite;
            StWrite:    state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Negative operands order in reverse of their magnitudes; +0/-0 are equal.
    always_comb begin
        any_nan   = a_nan_q | b_nan_q;
        both_zero = a_zero_q & b_zero_q;
        eq        = both_zero | (a_q == b_q);
        if (a_sign_q != b_sign_q) begin
            lt = a_sign_q & ~both_zero;
        end else if (a_sign_q) begin
            lt = a_q[EXP_MSB:0] > b_q[EXP_MSB:0];
        end else begin
            lt = a_q[EXP_MSB:0] < b_q[EXP_MSB:0];
        end
        unique case (cond_q)
            CondEq:  result = eq;
            CondLt:  result = lt;
            CondLe:  result = lt | eq;
            default: result = 1'b0;
        endcase
        if (any_nan) result = 1'b0;
    end

`ifdef FP_COMPARE_INVALID_EN
    always_comb begin
        invalid = (((cond_q == CondLt) || (cond_q == CondLe)) && any_nan) ||
                  ((cond_q == CondEq) && (a_snan_q || b_snan_q));
    end
`endif

    always_ff @(posedge iCLK or negedge iCLR_N) begin
        if (!iCLR_N) begin
            a_q        <= '0;
            b_q        <= '0;
            cond_q     <= '0;
            flag_sel_q <= '0;
            a_nan_q    <= 1'b0;
            a_zero_q   <= 1'b0;
            a_sign_q   <= 1'b0;
            b_nan_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            flag_q     <= '0;
            data_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && iStart) begin
                a_q        <= iA;
                b_q        <= iB;
                cond_q     <= iCond;
                flag_sel_q <= iFlagSel;
            end
            if (state_q == StClassify) begin
                a_nan_q  <= a_nan;
                a_zero_q <= a_zero;
                a_sign_q <= a_sign;
                b_nan_q  <= b_nan;
                b_zero_q <= b_zero;
                b_sign_q <= b_sign;
            end
            // Output values change only on entry to WRITE and hold afterwards.
            if (state_q == StCompare) begin
                flag_q <= flag_sel_q;
                data_q <= result;
            end
        end
    end

`ifdef FP_COMPARE_INVALID_EN
    always_ff @(posedge iCLK or negedge iCLR_N) begin
        if (!iCLR_N) begin
            a_snan_q  <= 1'b0;
            b_snan_q  <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            if (state_q == StClassify) begin
                a_snan_q <= a_snan;
                b_snan_q <= b_snan;
            end
            if (state_q == StCompare) begin
                invalid_q <= invalid;
            end
        end
    end
`endif

    // Output decode
    always_comb begin
        oBusy      = 1'b0;
        oFlagWrite = 1'b0;
        oDone      = 1'b0;
        oFlag      = flag_q;
        oData      = data_q;
`ifdef FP_COMPARE_INVALID_EN
        oInvalid   = 1'b0;
`endif
        unique case (state_q)
            StIdle:     oBusy = 1'b0;
            StClassify: oBusy = 1'b1;
            StCompare:  oBusy = 1'b1;
            StWrite: begin
                oBusy      = 1'b1;
                oFlagWrite = 1'b1;
                oDone      = 1'b1;
`ifdef FP_COMPARE_INVALID_EN
                oInvalid   = invalid_q;
`endif
            end
            default:    oBusy = 1'b0;
        endcase
    end

endmodule
